// File: rtl/dec_buffer.sv
// Ping-pong frame assembler: collects BEATS input beats into one wide codeword frame,
// flags framing errors, and presents whole frames to the decoder with valid/ready.
module dec_buffer #(
    parameter int SYM_NUM   = 4,
    parameter int SYM_WIDTH = 8,
    parameter int BEATS     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SYM_NUM*SYM_WIDTH-1:0]         in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [BEATS*SYM_NUM*SYM_WIDTH-1:0]   out_data,
    output logic                                 out_err
);

    localparam int BW = SYM_NUM * SYM_WIDTH;
    localparam int CW = (BEATS > 2) ? $clog2(BEATS) : 1;

    logic [BW-1:0] r_slot [2][BEATS];
    logic [1:0]    r_full;
    logic [1:0]    r_err;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [CW-1:0] r_cnt;

    logic w_accept;
    logic w_last_beat;
    logic w_close;
    logic w_err;
    logic w_drain;

    assign in_ready    = !r_full[r_wr_bank];
    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_cnt == CW'(BEATS - 1));
    assign w_close     = w_accept && (w_last_beat || in_last);
    // Early close and missing last are the two cases where in_last disagrees with the count.
    assign w_err       = in_last ^ w_last_beat;
    assign w_drain     = out_valid && out_ready;

    assign out_valid = r_full[r_rd_bank];
    assign out_err   = r_err[r_rd_bank];

    // Slot k holds beat k; the oldest beat lands in the most significant symbols.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_out
        assign out_data[(BEATS-1-gi)*BW +: BW] = r_slot[r_rd_bank][gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < BEATS; s++) begin
                    r_slot[b][s] <= '0;
                end
            end
        end else if (w_accept) begin
            // The first beat also wipes stale data so an early close leaves zeros behind.
            for (int s = 0; s < BEATS; s++) begin
                if (r_cnt == CW'(s)) begin
                    r_slot[r_wr_bank][s] <= in_data;
                end else if (r_cnt == '0) begin
                    r_slot[r_wr_bank][s] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_err     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_close ? '0 : r_cnt + CW'(1);
            end
            // A close always targets the bank that is not full, so it cannot collide with a drain.
            if (w_close) begin
                r_full[r_wr_bank] <= 1'b1;
                r_err[r_wr_bank]  <= w_err;
                r_wr_bank         <= !r_wr_bank;
            end
            if (w_drain) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= !r_rd_bank;
            end
        end
    end

endmodule
